// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the slave RAM arbiter.
// State encoding, owner codes and default widths.
package i2c_slave_pkg;

  localparam int DFLT_ADDR_W = 8;
  localparam int DFLT_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic OWN_I2C  = 1'b0;
  localparam logic OWN_HOST = 1'b1;

endpackage

// File: rtl/i2c_slave_mem_arbiter_if.sv
// Requester, RAM and status signals of the RAM arbiter.
// master = requesters/RAM side, slave = arbiter.
interface i2c_slave_mem_arbiter_if
  import i2c_slave_pkg::*;
#(
  parameter int ADDR_W = DFLT_ADDR_W,
  parameter int DATA_W = DFLT_DATA_W
);

  logic              i2c_req;
  logic              i2c_we;
  logic [ADDR_W-1:0] i2c_addr;
  logic [DATA_W-1:0] i2c_wdata;
  logic              i2c_ack;
  logic [DATA_W-1:0] i2c_rdata;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ack;
  logic [DATA_W-1:0] host_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic              owner;

  modport master (
    output i2c_req, i2c_we, i2c_addr, i2c_wdata,
    input  i2c_ack, i2c_rdata,
    output host_req, host_we, host_addr, host_wdata,
    input  host_ack, host_rdata,
    input  mem_addr, mem_wdata, mem_we, mem_rd,
    output mem_rdata,
    input  busy, owner
  );

  modport slave (
    input  i2c_req, i2c_we, i2c_addr, i2c_wdata,
    output i2c_ack, i2c_rdata,
    input  host_req, host_we, host_addr, host_wdata,
    output host_ack, host_rdata,
    output mem_addr, mem_wdata, mem_we, mem_rd,
    input  mem_rdata,
    output busy, owner
  );

endinterface

// File: rtl/i2c_arb_starve_cnt.sv
// Host starvation counter for the RAM arbiter.
// Saturating 8-bit wait count with threshold compare.
module i2c_arb_starve_cnt #(
  parameter int MAX_WAIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic ge
);

  localparam logic [7:0] LIMIT = 8'(MAX_WAIT);

  logic [7:0] cnt;

  // count host waiting cycles, hold at 255, clear wins over inc
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && cnt != 8'hFF) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign ge = cnt >= LIMIT;

endmodule

// File: rtl/i2c_slave_mem_arbiter.sv
// Single-port slave RAM arbiter: i2c has priority,
// host wins once it has waited long enough.
module i2c_slave_mem_arbiter
  import i2c_slave_pkg::*;
#(
  parameter int ADDR_W        = DFLT_ADDR_W,
  parameter int DATA_W        = DFLT_DATA_W,
  parameter int RD_LAT        = 1,
  parameter int HOST_MAX_WAIT = 16
) (
  input logic clk,
  input logic reset,
  i2c_slave_mem_arbiter_if.slave bus
);

  localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

  state_t            state;
  logic              owner_q;
  logic              we_q;
  logic              busy_q;
  logic [1:0]        lat_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] i2c_rd_q;
  logic [DATA_W-1:0] host_rd_q;
  logic              mem_we_q;
  logic              mem_rd_q;
  logic              i2c_ack_q;
  logic              host_ack_q;

  logic              host_ge;
  logic              any_req;
  logic              pick_host;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              cnt_inc;
  logic              cnt_clr;

  assign any_req   = bus.i2c_req | bus.host_req;
  assign pick_host = bus.host_req
                   & (~bus.i2c_req | host_ge);
  assign sel_we    = pick_host ? bus.host_we
                               : bus.i2c_we;
  assign sel_addr  = pick_host ? bus.host_addr
                               : bus.i2c_addr;
  assign sel_wdata = pick_host ? bus.host_wdata
                               : bus.i2c_wdata;

  assign cnt_inc = bus.host_req
                 & ~((state != ST_IDLE)
                   & (owner_q == OWN_HOST));
  assign cnt_clr = ~bus.host_req
                 | ((state == ST_IDLE) & pick_host);

  i2c_arb_starve_cnt #(
    .MAX_WAIT (HOST_MAX_WAIT)
  ) u_starve (
    .clk   (clk),
    .reset (reset),
    .inc   (cnt_inc),
    .clr   (cnt_clr),
    .ge    (host_ge)
  );

  // transaction sequencer with registered strobes, acks and rdata
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      owner_q    <= OWN_I2C;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      lat_cnt    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      i2c_rd_q   <= '0;
      host_rd_q  <= '0;
      mem_we_q   <= 1'b0;
      mem_rd_q   <= 1'b0;
      i2c_ack_q  <= 1'b0;
      host_ack_q <= 1'b0;
    end else begin
      mem_we_q   <= 1'b0;
      mem_rd_q   <= 1'b0;
      i2c_ack_q  <= 1'b0;
      host_ack_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (any_req) begin
            owner_q  <= pick_host ? OWN_HOST
                                  : OWN_I2C;
            we_q     <= sel_we;
            addr_q   <= sel_addr;
            wdata_q  <= sel_wdata;
            mem_we_q <= sel_we;
            mem_rd_q <= ~sel_we;
            busy_q   <= 1'b1;
            state    <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (we_q) begin
            i2c_ack_q  <= owner_q == OWN_I2C;
            host_ack_q <= owner_q == OWN_HOST;
            state      <= ST_DONE;
          end else begin
            lat_cnt <= LAT_INIT;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (lat_cnt != 2'd0) begin
            lat_cnt <= lat_cnt - 2'd1;
          end else begin
            if (owner_q == OWN_HOST) begin
              host_rd_q  <= bus.mem_rdata;
              host_ack_q <= 1'b1;
            end else begin
              i2c_rd_q  <= bus.mem_rdata;
              i2c_ack_q <= 1'b1;
            end
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_rd     = mem_rd_q;
  assign bus.i2c_ack    = i2c_ack_q;
  assign bus.host_ack   = host_ack_q;
  assign bus.i2c_rdata  = i2c_rd_q;
  assign bus.host_rdata = host_rd_q;
  assign bus.busy       = busy_q;
  assign bus.owner      = owner_q;

endmodule

// File: tb/tb_i2c_slave_mem_arbiter.sv
// Bench for the slave RAM arbiter: directed steps plus
// randomized traffic against a transaction-level model.
module tb_i2c_slave_mem_arbiter;

  localparam int HMW_A = 4;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  i2c_slave_mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) ifa ();
  i2c_slave_mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) ifb ();

  i2c_slave_mem_arbiter #(
    .ADDR_W(8), .DATA_W(8),
    .RD_LAT(LAT_A), .HOST_MAX_WAIT(HMW_A)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );

  i2c_slave_mem_arbiter #(
    .ADDR_W(8), .DATA_W(8),
    .RD_LAT(LAT_B), .HOST_MAX_WAIT(16)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  // RAM models: data appears RD_LAT cycles after mem_rd
  logic [7:0] ram_a [256];
  logic [7:0] ram_b [256];
  logic       pa_v;
  logic [7:0] pa_d;
  logic       pb_v0, pb_v1, pb_v2;
  logic [7:0] pb_d0, pb_d1, pb_d2;

  always @(posedge clk) begin
    if (ifa.mem_we) ram_a[ifa.mem_addr] <= ifa.mem_wdata;
    pa_v <= ifa.mem_rd;
    pa_d <= ram_a[ifa.mem_addr];
    if (ifb.mem_we) ram_b[ifb.mem_addr] <= ifb.mem_wdata;
    pb_v0 <= ifb.mem_rd;
    pb_d0 <= ram_b[ifb.mem_addr];
    pb_v1 <= pb_v0;
    pb_d1 <= pb_d0;
    pb_v2 <= pb_v1;
    pb_d2 <= pb_d1;
  end

  assign ifa.mem_rdata = pa_v ? pa_d : 8'hEE;
  assign ifb.mem_rdata = pb_v2 ? pb_d2 : 8'hEE;

  // reference model state
  logic [7:0] shadow_a [256];
  logic [7:0] shadow_b [256];
  logic [7:0] known_q [$];
  logic [7:0] exp_i2c_rd;
  logic [7:0] exp_host_rd;
  logic [7:0] exp_b_rd;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic pick_op(input bit wr_only,
                         output bit we,
                         output logic [7:0] addr,
                         output logic [7:0] wd);
    we = wr_only || known_q.size() == 0
         || ($urandom_range(0, 1) == 1);
    if (we) addr = 8'($urandom);
    else addr = known_q[$urandom_range(0, known_q.size() - 1)];
    wd = 8'($urandom);
  endtask

  task automatic complete_a(input bit h, input bit we,
                            input logic [7:0] addr,
                            input logic [7:0] wd,
                            input string tag);
    if (we) begin
      shadow_a[addr] = wd;
      known_q.push_back(addr);
    end else if (h) begin
      exp_host_rd = shadow_a[addr];
    end else begin
      exp_i2c_rd = shadow_a[addr];
    end
    chk({tag, "_i2c_rd"}, ifa.i2c_rdata, exp_i2c_rd);
    chk({tag, "_host_rd"}, ifa.host_rdata, exp_host_rd);
  endtask

  task automatic txn_a(input bit h, input bit we,
                       input logic [7:0] addr,
                       input logic [7:0] wd,
                       input bit drop, input string tag);
    int lat;
    bit seen;
    logic own_ack, oth_ack;
    lat = we ? 2 : 2 + LAT_A;
    if (h) begin
      ifa.host_we = we; ifa.host_addr = addr;
      ifa.host_wdata = wd; ifa.host_req = 1'b1;
    end else begin
      ifa.i2c_we = we; ifa.i2c_addr = addr;
      ifa.i2c_wdata = wd; ifa.i2c_req = 1'b1;
    end
    seen = 0;
    for (int k = 0; k < 16 && !seen; k++) begin
      @(negedge clk);
      own_ack = h ? ifa.host_ack : ifa.i2c_ack;
      oth_ack = h ? ifa.i2c_ack : ifa.host_ack;
      chk({tag, "_oth_ack"}, oth_ack, 0);
      if (k == 1) begin
        chk({tag, "_we"}, ifa.mem_we, we);
        chk({tag, "_rd"}, ifa.mem_rd, !we);
        chk({tag, "_addr"}, ifa.mem_addr, addr);
        if (we) chk({tag, "_wdata"}, ifa.mem_wdata, wd);
        chk({tag, "_owner"}, ifa.owner, h);
        chk({tag, "_busy"}, ifa.busy, 1);
        if (drop) begin
          ifa.i2c_req = 1'b0; ifa.host_req = 1'b0;
        end
      end
      if (own_ack) begin
        seen = 1;
        chk({tag, "_lat"}, k, lat);
      end
    end
    if (!seen) chk({tag, "_timeout"}, 0, 1);
    else complete_a(h, we, addr, wd, tag);
    @(posedge clk); #1;
    ifa.i2c_req = 1'b0; ifa.host_req = 1'b0;
  endtask

  // both requesters at once; i2c keeps re-requesting
  task automatic contend_a(input int n, input bit wr_only,
                           input string tag);
    bit         iwe [8];
    logic [7:0] ia [8];
    logic [7:0] iw [8];
    bit         hwe;
    logic [7:0] ha, hw;
    int         w, pred, served, host_at;
    bit         hdone, ia_k, ha_k;
    for (int i = 0; i < n; i++) pick_op(wr_only, iwe[i], ia[i], iw[i]);
    pick_op(wr_only, hwe, ha, hw);
    w = 0; pred = 0;
    while (w < HMW_A && pred < n) begin
      w += iwe[pred] ? 3 : 3 + LAT_A;
      pred++;
    end
    served = 0; host_at = -1; hdone = 0;
    ifa.i2c_we = iwe[0]; ifa.i2c_addr = ia[0];
    ifa.i2c_wdata = iw[0]; ifa.i2c_req = 1'b1;
    ifa.host_we = hwe; ifa.host_addr = ha;
    ifa.host_wdata = hw; ifa.host_req = 1'b1;
    for (int c = 0; c < 200 && !(hdone && served == n); c++) begin
      @(negedge clk);
      if (ifa.owner && (ifa.mem_we || ifa.mem_rd))
        chk({tag, "_cnt_clr"}, dut_a.u_starve.cnt, 0);
      ia_k = ifa.i2c_ack;
      ha_k = ifa.host_ack;
      if (ia_k) begin
        if (served < n)
          complete_a(0, iwe[served], ia[served], iw[served],
                     $sformatf("%s_i%0d", tag, served));
        else chk({tag, "_extra_ack"}, 1, 0);
        served++;
      end
      if (ha_k) begin
        complete_a(1, hwe, ha, hw, {tag, "_h"});
        host_at = served;
        hdone = 1;
      end
      @(posedge clk); #1;
      if (ia_k) begin
        if (served < n) begin
          ifa.i2c_we = iwe[served]; ifa.i2c_addr = ia[served];
          ifa.i2c_wdata = iw[served];
        end else begin
          ifa.i2c_req = 1'b0;
        end
      end
      if (ha_k) ifa.host_req = 1'b0;
    end
    chk({tag, "_finished"}, hdone && served == n, 1);
    chk({tag, "_host_after"}, host_at, pred);
    ifa.i2c_req = 1'b0; ifa.host_req = 1'b0;
  endtask

  task automatic txn_b(input bit we, input logic [7:0] addr,
                       input logic [7:0] wd, input string tag);
    int lat;
    bit seen;
    lat = we ? 2 : 2 + LAT_B;
    ifb.i2c_we = we; ifb.i2c_addr = addr;
    ifb.i2c_wdata = wd; ifb.i2c_req = 1'b1;
    seen = 0;
    for (int k = 0; k < 16 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk({tag, "_we"}, ifb.mem_we, we);
        chk({tag, "_rd"}, ifb.mem_rd, !we);
      end
      if (k >= 1) chk({tag, "_addr_hold"}, ifb.mem_addr, addr);
      if (ifb.i2c_ack) begin
        seen = 1;
        chk({tag, "_lat"}, k, lat);
      end
    end
    if (!seen) begin
      chk({tag, "_timeout"}, 0, 1);
    end else begin
      if (we) shadow_b[addr] = wd;
      else exp_b_rd = shadow_b[addr];
      chk({tag, "_rdata"}, ifb.i2c_rdata, exp_b_rd);
      chk({tag, "_host_rd"}, ifb.host_rdata, 0);
    end
    @(posedge clk); #1;
    ifb.i2c_req = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, ifa.busy, 0);
    chk({tag, "_owner"}, ifa.owner, 0);
    chk({tag, "_i2c_ack"}, ifa.i2c_ack, 0);
    chk({tag, "_host_ack"}, ifa.host_ack, 0);
    chk({tag, "_mem_we"}, ifa.mem_we, 0);
    chk({tag, "_mem_rd"}, ifa.mem_rd, 0);
    chk({tag, "_mem_addr"}, ifa.mem_addr, 0);
    chk({tag, "_mem_wdata"}, ifa.mem_wdata, 0);
    chk({tag, "_i2c_rdata"}, ifa.i2c_rdata, 0);
    chk({tag, "_host_rdata"}, ifa.host_rdata, 0);
  endtask

  initial begin
    reset = 1'b1;
    ifa.i2c_req = 0; ifa.i2c_we = 0;
    ifa.i2c_addr = 0; ifa.i2c_wdata = 0;
    ifa.host_req = 0; ifa.host_we = 0;
    ifa.host_addr = 0; ifa.host_wdata = 0;
    ifb.i2c_req = 0; ifb.i2c_we = 0;
    ifb.i2c_addr = 0; ifb.i2c_wdata = 0;
    ifb.host_req = 0; ifb.host_we = 0;
    ifb.host_addr = 0; ifb.host_wdata = 0;
    exp_i2c_rd = 0; exp_host_rd = 0; exp_b_rd = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    chk("reset_b_busy", ifb.busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    txn_a(0, 1, 8'h05, 8'hA5, 0, "i2c_wr05");
    txn_a(1, 0, 8'h05, 8'h00, 0, "host_rd05");
    txn_a(0, 1, 8'h80, 8'h3C, 1, "i2c_wr_drop");
    txn_a(1, 0, 8'h80, 8'h00, 1, "host_rd_drop");

    contend_a(1, 1, "both_first");
    contend_a(5, 1, "starve_wr");
    contend_a(5, 0, "starve_mix");

    // reset while a read sits in WAIT
    ifa.i2c_we = 0; ifa.i2c_addr = 8'h05; ifa.i2c_req = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_busy", ifa.busy, 1);
    chk("midrst_ack", ifa.i2c_ack, 0);
    reset = 1'b1;
    ifa.i2c_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("midrst");
    @(posedge clk); #1;
    reset = 1'b0;
    exp_i2c_rd = 0; exp_host_rd = 0; exp_b_rd = 0;
    txn_a(0, 0, 8'h05, 8'h00, 0, "reissue");

    for (int i = 0; i < 40; i++) begin
      bit         h, we, dr;
      logic [7:0] a, d;
      h  = 1'($urandom_range(0, 1));
      dr = ($urandom_range(0, 3) == 0);
      pick_op(0, we, a, d);
      txn_a(h, we, a, d, dr, $sformatf("rnd%0d", i));
    end

    for (int i = 0; i < 8; i++)
      contend_a(int'($urandom_range(1, 6)), 0,
                $sformatf("rcon%0d", i));

    txn_b(1, 8'h33, 8'h5C, "b_wr33");
    txn_b(0, 8'h33, 8'h00, "b_rd33");
    txn_b(1, 8'hFF, 8'h01, "b_wrFF");
    txn_b(0, 8'hFF, 8'h00, "b_rdFF");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
